// File: rtl/zone_scan_if.sv
// zone_scan_if: video timing in, accumulator controls and zone readout handshake out
interface zone_scan_if #(parameter int IDX_W = 5);
    logic             i_v_sync;
    logic             i_h_sync;
    logic             i_data_en;
    logic             o_acc_en;
    logic [IDX_W-1:0] o_zone_idx;
    logic             o_acc_clr;
    logic             o_rd_valid;
    logic             i_rd_ready;
    logic             o_band_done;
    logic             o_overrun;
    logic [7:0]       o_overrun_cnt;
    modport slave (
        input  i_v_sync, i_h_sync, i_data_en, i_rd_ready,
        output o_acc_en, o_zone_idx, o_acc_clr, o_rd_valid, o_band_done, o_overrun, o_overrun_cnt
    );
    modport master (
        output i_v_sync, i_h_sync, i_data_en, i_rd_ready,
        input  o_acc_en, o_zone_idx, o_acc_clr, o_rd_valid, o_band_done, o_overrun, o_overrun_cnt
    );
endinterface

// File: rtl/zone_scan_ctrl.sv
// zone_scan_ctrl: zone accumulate/clear sequencing and readout drain; ZONE_OVERRUN_CNT_EN adds a saturating overrun counter
module zone_scan_ctrl #(
    parameter int ZONE_W   = 53,
    parameter int ZONE_H   = 45,
    parameter int ZONE_NUM = 24,
    parameter int IDX_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    zone_scan_if.slave sif
);
    localparam int CW = $clog2(ZONE_W);
    localparam int RW = $clog2(ZONE_H + 1);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, WAIT} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [IDX_W-1:0] zone_q, zone_d;
    logic             clr_q, clr_d, band_q, band_d, ovr_q, ovr_d;
    logic             vs_q, de_q, vs_rise, line_end, unused_h_sync;
    assign unused_h_sync = sif.i_h_sync;
    assign vs_rise  = sif.i_v_sync & ~vs_q;
    assign line_end = ~sif.i_data_en & de_q;
    // edge-detect copies follow the inputs even in reset so a held v_sync is not seen as a new frame
    always_ff @(posedge clk) begin
        vs_q <= sif.i_v_sync;
        de_q <= sif.i_data_en;
    end
    // state and position registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            zone_q  <= '0;
            clr_q   <= 1'b0;
            band_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            zone_q  <= zone_d;
            clr_q   <= clr_d;
            band_q  <= band_d;
            ovr_q   <= ovr_d;
        end
    end
    // next state: pixel tracking in ACCUM, index stepping in DRAIN, frame restarts on vs_rise
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        zone_d  = zone_q;
        clr_d   = 1'b0;
        band_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: if (vs_rise) begin
                state_d = ACCUM;
                clr_d   = 1'b1;
                row_d   = '0;
                col_d   = '0;
                zone_d  = '0;
            end
            ACCUM: if (vs_rise) begin
                clr_d  = 1'b1;
                row_d  = '0;
                col_d  = '0;
                zone_d = '0;
            end else if (line_end) begin
                col_d  = '0;
                zone_d = '0;
                row_d  = row_q + 1'b1;
                if (int'(row_q) == ZONE_H - 1) begin
                    band_d  = 1'b1;
                    state_d = DRAIN;
                end
            end else if (sif.i_data_en && int'(zone_q) < ZONE_NUM) begin
                col_d  = (int'(col_q) == ZONE_W - 1) ? '0 : col_q + 1'b1;
                zone_d = (int'(col_q) == ZONE_W - 1) ? zone_q + 1'b1 : zone_q;
            end
            DRAIN: if (sif.i_rd_ready && int'(zone_q) == ZONE_NUM - 1) begin
                clr_d   = 1'b1;
                state_d = vs_rise ? ACCUM : WAIT;
                row_d   = '0;
                col_d   = '0;
                zone_d  = '0;
            end else if (vs_rise) begin
                ovr_d   = 1'b1;
                clr_d   = 1'b1;
                state_d = ACCUM;
                row_d   = '0;
                col_d   = '0;
                zone_d  = '0;
            end else if (sif.i_rd_ready) begin
                zone_d = zone_q + 1'b1;
            end
            WAIT: if (vs_rise) begin
                state_d = ACCUM;
                row_d   = '0;
                col_d   = '0;
                zone_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    assign sif.o_acc_en    = (state_q == ACCUM) & sif.i_data_en & (int'(zone_q) < ZONE_NUM)
                           & (int'(row_q) < ZONE_H) & ~clr_q;
    assign sif.o_zone_idx  = zone_q;
    assign sif.o_acc_clr   = clr_q;
    assign sif.o_rd_valid  = (state_q == DRAIN);
    assign sif.o_band_done = band_q;
    assign sif.o_overrun   = ovr_q;
`ifdef ZONE_OVERRUN_CNT_EN
    logic [7:0] cnt_q, cnt_d;
    // saturating count of aborted drains, cleared only by reset
    always_comb cnt_d = (ovr_d && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    // overrun counter register
    always_ff @(posedge clk) begin
        if (rst_n) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign sif.o_overrun_cnt = cnt_q;
`else
    assign sif.o_overrun_cnt = '0;
`endif
endmodule

// File: doc/zone_scan_ctrl.md
Name: zone_scan_ctrl

Overview:
Sequencer for the zone-averaging datapath, which splits the top band of each frame into ZONE_NUM horizontal zones (ZONE_W pixels wide, ZONE_H rows tall) and accumulates luma per zone.
This block tracks frame, line and pixel position from the video timing signals and issues accumulate, clear and zone-index controls to the accumulator bank.
Once the band is complete, it steps through every zone result with a valid/ready readout handshake toward the downstream consumer.
It sits between the video timing input and the zone accumulator/divider.

Parameters:
ZONE_W, 53, pixels per zone (horizontal)
ZONE_H, 45, rows accumulated per frame (band height)
ZONE_NUM, 24, number of zones per row
IDX_W, 5, zone index width; must satisfy 2^IDX_W >= ZONE_NUM

Ports:
clk  in  1  pixel clock; single clock domain
rst_n  in  1  reset, synchronous, active-high (despite the name)
i_v_sync  in  1  frame sync, active-high; frame start is its rising edge
i_h_sync  in  1  line sync, active-high (informational; line end is taken from i_data_en)
i_data_en  in  1  active-pixel enable
o_acc_en  out  1  accumulate current pixel into zone o_zone_idx
o_zone_idx  out  IDX_W  zone of current pixel; during DRAIN, the zone being read
o_acc_clr  out  1  one-cycle clear of all zone accumulators
o_rd_valid  out  1  zone o_zone_idx result is ready for readout
i_rd_ready  in  1  consumer accepts result
o_band_done  out  1  one-cycle pulse when row ZONE_H-1 ends
o_overrun  out  1  one-cycle pulse when a new frame aborts DRAIN
o_overrun_cnt  out  8  aborted-drain count (see Optional Feature)

Behaviour:
- Reset (rst_n=1 at a clk edge): state=IDLE; all counters 0.
  - Outputs at reset: o_acc_en=0, o_zone_idx=0, o_acc_clr=0, o_rd_valid=0, o_band_done=0, o_overrun=0, o_overrun_cnt=0.
  - A reset asserted mid-frame aborts everything; the block then waits for the next v_sync rising edge.
- Edge detection uses registered copies of i_v_sync and i_data_en.
  - vs_rise = i_v_sync & ~vs_d.
  - line_end = ~i_data_en & de_d.
- States:
  - IDLE: on vs_rise, pulse o_acc_clr (next cycle) and go to ACCUM with row=0.
  - ACCUM: per-pixel tracking.
    - col_in_zone counts i_data_en cycles 0..ZONE_W-1; at ZONE_W-1 it wraps to 0 and zone increments.
    - zone saturates at ZONE_NUM; pixels with zone==ZONE_NUM are not accumulated.
    - col_in_zone and zone reset to 0 on line_end.
    - o_acc_en = i_data_en & (zone<ZONE_NUM) & (row<ZONE_H), combinational from registered counters; o_zone_idx=zone in the same cycle. Latency is 0 relative to the pixel.
    - On line_end, row++. On line_end with row==ZONE_H-1: pulse o_band_done, set o_zone_idx=0, go to DRAIN.
    - vs_rise while in ACCUM: restart (clear pulse, row=0). Not an overrun.
  - DRAIN: o_rd_valid=1, o_acc_en=0.
    - A handshake (o_rd_valid & i_rd_ready) advances o_zone_idx.
    - Handshake at index ZONE_NUM-1: o_rd_valid drops next cycle, o_acc_clr pulses, go to WAIT.
    - o_zone_idx is stable while valid & ~ready.
    - vs_rise in DRAIN: pulse o_overrun, pulse o_acc_clr, row=0, go to ACCUM. Remaining zones are discarded.
  - WAIT: ignore pixels; on vs_rise go to ACCUM exactly as from IDLE. The clear has already been issued, so the IDLE clear is skipped here.
- Simultaneous events:
  - vs_rise and the final handshake in the same cycle: the handshake completes, no o_overrun, go to ACCUM.
  - o_acc_clr and o_acc_en are never both 1.
- Counter widths:
  - col_in_zone: $clog2(ZONE_W).
  - row: $clog2(ZONE_H+1).
  - zone: IDX_W; saturating, never wraps.

Optional Feature:
- Macro ZONE_OVERRUN_CNT_EN.
  - Defined: o_overrun_cnt increments on each o_overrun pulse, saturates at 255, and clears only on reset.
  - Undefined: no counter logic; o_overrun_cnt is tied to 0. o_overrun pulses are still generated.

Test Plan:
- Reset held 3 cycles mid-ACCUM -> all outputs 0; no o_acc_en until after the next vs_rise.
- Frame with 1280-pixel lines, 60 rows -> o_acc_en high for the first 1272 pixels (24*53) of rows 0..44 only; o_zone_idx steps 0..23 every 53 pixels; o_band_done pulses once at end of row 44.
- DRAIN with i_rd_ready always 1 -> 24 consecutive valid cycles, idx 0..23, then one o_acc_clr pulse.
- DRAIN with i_rd_ready toggling 1,0,0 -> idx holds during the 0 cycles; the 24 results take 72 cycles; no index is skipped.
- vs_rise after 10 handshakes -> o_overrun=1, o_acc_clr=1, state ACCUM, row=0; with the macro defined, o_overrun_cnt=1.
- 300 consecutive overruns with the macro defined -> o_overrun_cnt=255; with the macro undefined -> 0.
